// File: rtl/mse_metric_acc_if.sv
// ---------------------------------------------------------------------------
// mse_metric_acc_if
// Bundle of the sample stream and the result bus of the MSE metric sink.
//   start        : begin a new measurement window
//   in_valid     : approx/exact pair valid this cycle
//   approx/exact : signed FIR outputs (approximate and exact reference)
//   busy         : window in progress
//   done         : one-cycle pulse, results valid
//   sse/mse      : sum / mean of squared error
//   max_abs_err  : largest |approx-exact| seen in the window
//   overflow     : SSE saturated during the window
// master = stream source / result consumer, slave = the metric block.
// ---------------------------------------------------------------------------
interface mse_metric_acc_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
);
  logic                     start;
  logic                     in_valid;
  logic signed [DATA_W-1:0] approx;
  logic signed [DATA_W-1:0] exact;
  logic                     busy;
  logic                     done;
  logic [ACC_W-1:0]         sse;
  logic [ACC_W-1:0]         mse;
  logic [DATA_W:0]          max_abs_err;
  logic                     overflow;

  modport master (
    output start, in_valid, approx, exact,
    input  busy, done, sse, mse, max_abs_err, overflow
  );

  modport slave (
    input  start, in_valid, approx, exact,
    output busy, done, sse, mse, max_abs_err, overflow
  );
endinterface

// File: rtl/mse_metric_acc.sv
// ---------------------------------------------------------------------------
// mse_metric_acc
// Streaming error-metric sink. After a start, discards SKIP valid sample
// pairs, then accumulates the squared error of 2**LOG2_N valid pairs and
// reports SSE (saturating), MSE (SSE >> LOG2_N, truncated) and the maximum
// absolute error. done pulses for one cycle when the results are final.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts a window, no done)
//   bus  : mse_metric_acc_if slave (stream in, results out)
// ---------------------------------------------------------------------------
module mse_metric_acc #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 10,
  parameter int SKIP   = 2,
  parameter int ACC_W  = 48
) (
  input  logic           clk,
  input  logic           rst,
  mse_metric_acc_if.slave bus
);

  localparam int SQ_W    = 2 * (DATA_W + 1);
  // One bit wider than either operand so the saturation compare sees the carry.
  localparam int SUM_W   = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int SKIP_CW = (SKIP > 1) ? $clog2(SKIP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_ACCUM,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [SKIP_CW-1:0]  skip_cnt_q, skip_cnt_d;
  logic [LOG2_N-1:0]   acc_cnt_q, acc_cnt_d;
  logic                p1_valid_q, p1_valid_d;
  logic [DATA_W:0]     p1_abs_q, p1_abs_d;
  logic [ACC_W-1:0]    sse_q, sse_d;
  logic [ACC_W-1:0]    mse_q, mse_d;
  logic [DATA_W:0]     mae_q, mae_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Difference in DATA_W+1 bits so extreme inputs never wrap.
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]        abs_in;
  logic [SQ_W-1:0]        sq;
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       acc_max_ext;

  assign diff        = {bus.approx[DATA_W-1], bus.approx} - {bus.exact[DATA_W-1], bus.exact};
  assign abs_in      = diff[DATA_W] ? DATA_W'(0) - diff : diff;
  assign sq          = SQ_W'(p1_abs_q) * SQ_W'(p1_abs_q);
  assign sum         = SUM_W'(sse_q) + SUM_W'(sq);
  assign acc_max_ext = SUM_W'({ACC_W{1'b1}});

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    p1_valid_d = 1'b0;
    p1_abs_d   = p1_abs_q;
    sse_d      = sse_q;
    mse_d      = mse_q;
    mae_d      = mae_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    // Stage 2: fold the previously registered sample into the results.
    if (p1_valid_q) begin
      if (sum > acc_max_ext) begin
        sse_d = {ACC_W{1'b1}};
        ovf_d = 1'b1;
      end else begin
        sse_d = ACC_W'(sum);
      end
      if (p1_abs_q > mae_q) begin
        mae_d = p1_abs_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sse_d      = '0;
          mse_d      = '0;
          mae_d      = '0;
          ovf_d      = 1'b0;
          skip_cnt_d = '0;
          acc_cnt_d  = '0;
          state_d    = (SKIP == 0) ? S_ACCUM : S_SKIP;
        end
      end
      S_SKIP: begin
        if (bus.in_valid) begin
          if (skip_cnt_q == SKIP_CW'(SKIP - 1)) begin
            state_d = S_ACCUM;
          end else begin
            skip_cnt_d = skip_cnt_q + SKIP_CW'(1);
          end
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          p1_valid_d = 1'b1;
          p1_abs_d   = abs_in;
          acc_cnt_d  = acc_cnt_q + LOG2_N'(1);
          // Counter wraps to zero exactly on the Nth sample.
          if (acc_cnt_q == {LOG2_N{1'b1}}) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_FINISH;
      end
      S_FINISH: begin
        mse_d   = sse_q >> LOG2_N;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      acc_cnt_q  <= '0;
      p1_valid_q <= 1'b0;
      p1_abs_q   <= '0;
      sse_q      <= '0;
      mse_q      <= '0;
      mae_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      p1_valid_q <= p1_valid_d;
      p1_abs_q   <= p1_abs_d;
      sse_q      <= sse_d;
      mse_q      <= mse_d;
      mae_q      <= mae_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sse         = sse_q;
  assign bus.mse         = mse_q;
  assign bus.max_abs_err = mae_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_mse_metric_acc.sv
// ---------------------------------------------------------------------------
// tb_mse_metric_acc
// Three instances with small windows (N=8): plain, SKIP=2, and a 34-bit
// accumulator that saturates. Expected results are pushed to a per-instance
// queue as each window is driven and compared when that instance pulses done.
// ---------------------------------------------------------------------------
module tb_mse_metric_acc;

  typedef struct {
    logic [63:0] sse;
    logic [63:0] mse;
    logic [16:0] mae;
    logic        ovf;
    int          dcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt [3];

  logic               st [3];
  logic               iv [3];
  logic signed [15:0] ap [3];
  logic signed [15:0] ex [3];

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mse_metric_acc_if #(.DATA_W(16), .ACC_W(48)) if0 ();
  mse_metric_acc_if #(.DATA_W(16), .ACC_W(48)) if1 ();
  mse_metric_acc_if #(.DATA_W(16), .ACC_W(34)) if2 ();

  assign if0.start = st[0]; assign if0.in_valid = iv[0]; assign if0.approx = ap[0]; assign if0.exact = ex[0];
  assign if1.start = st[1]; assign if1.in_valid = iv[1]; assign if1.approx = ap[1]; assign if1.exact = ex[1];
  assign if2.start = st[2]; assign if2.in_valid = iv[2]; assign if2.approx = ap[2]; assign if2.exact = ex[2];

  mse_metric_acc #(.DATA_W(16), .LOG2_N(3), .SKIP(0), .ACC_W(48)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mse_metric_acc #(.DATA_W(16), .LOG2_N(3), .SKIP(2), .ACC_W(48)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mse_metric_acc #(.DATA_W(16), .LOG2_N(3), .SKIP(0), .ACC_W(34)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic cmp_res(input int d, input exp_t e, input logic [63:0] s, input logic [63:0] m,
                         input logic [16:0] mae, input logic ov);
    check_val($sformatf("d%0d_sse", d), s, e.sse);
    check_val($sformatf("d%0d_mse", d), m, e.mse);
    check_val($sformatf("d%0d_max_abs_err", d), 64'(mae), 64'(e.mae));
    check_val($sformatf("d%0d_overflow", d), 64'(ov), 64'(e.ovf));
    check_val($sformatf("d%0d_done_cycle", d), 64'(cyc), 64'(e.dcyc));
    $display("d%0d window: sse=%0d mse=%0d max_abs_err=%0d overflow=%0d", d, s, m, mae, ov);
  endtask

  // Result monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      done_cnt[0]++;
      if (q0.size() == 0) check_val("d0_unexpected_done", 64'(1), 64'(0));
      else begin
        e0 = q0.pop_front();
        cmp_res(0, e0, 64'(if0.sse), 64'(if0.mse), if0.max_abs_err, if0.overflow);
      end
    end
    if (if1.done === 1'b1) begin
      done_cnt[1]++;
      if (q1.size() == 0) check_val("d1_unexpected_done", 64'(1), 64'(0));
      else begin
        e1 = q1.pop_front();
        cmp_res(1, e1, 64'(if1.sse), 64'(if1.mse), if1.max_abs_err, if1.overflow);
      end
    end
    if (if2.done === 1'b1) begin
      done_cnt[2]++;
      if (q2.size() == 0) check_val("d2_unexpected_done", 64'(1), 64'(0));
      else begin
        e2 = q2.pop_front();
        cmp_res(2, e2, 64'(if2.sse), 64'(if2.mse), if2.max_abs_err, if2.overflow);
      end
    end
  end

  function automatic logic busy_of(input int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  // Drive one cycle; inputs change #1 after a rising edge.
  task automatic step(input int d, input logic s, input logic v,
                      input logic signed [15:0] a, input logic signed [15:0] e);
    st[d] = s; iv[d] = v; ap[d] = a; ex[d] = e;
    @(posedge clk); #1;
    st[d] = 1'b0; iv[d] = 1'b0;
  endtask

  // One measurement window of 8 identical pairs (a,e), preceded on the SKIP
  // instance by two pairs (sa,se) that must be discarded.
  task automatic run_window(input int d, input logic signed [15:0] a, input logic signed [15:0] e,
                            input logic signed [15:0] sa, input logic signed [15:0] se,
                            input bit gaps, input bit mid_start);
    int                 nskip = (d == 1) ? 2 : 0;
    int                 accw  = (d == 2) ? 34 : 48;
    int                 n0;
    int                 last_c = 0;
    logic [64:0]        acc = '0;
    logic [64:0]        mx;
    logic signed [16:0] df;
    logic [16:0]        ab;
    logic [64:0]        sq;
    exp_t               x;
    mx = (65'(1) << accw) - 65'(1);
    df = {a[15], a} - {e[15], e};
    ab = df[16] ? 17'(-df) : 17'(df);
    sq = 65'(ab) * 65'(ab);
    x.ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + sq;
      if (acc > mx) begin
        acc   = mx;
        x.ovf = 1'b1;
      end
    end
    x.sse = 64'(acc);
    x.mse = x.sse >> 3;
    x.mae = ab;
    n0 = done_cnt[d];

    step(d, 1'b1, 1'b0, 16'sd0, 16'sd0);
    check_val($sformatf("d%0d_busy_after_start", d), 64'(busy_of(d)), 64'(1));
    for (int i = 0; i < nskip; i++) step(d, 1'b0, 1'b1, sa, se);
    for (int i = 0; i < 8; i++) begin
      if (gaps) step(d, mid_start && (i == 4), 1'b0, 16'sh7fff, 16'sh8000);
      last_c = cyc;
      step(d, 1'b0, 1'b1, a, e);
    end
    x.dcyc = last_c + 3;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
    repeat (8) @(posedge clk);
    #1;
    check_val($sformatf("d%0d_done_count", d), 64'(done_cnt[d]), 64'(n0 + 1));
    check_val($sformatf("d%0d_busy_after_done", d), 64'(busy_of(d)), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; iv[i] = 1'b0; ap[i] = '0; ex[i] = '0; done_cnt[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_busy", 64'(if0.busy), 64'(0));
    check_val("reset_done", 64'(if0.done), 64'(0));
    check_val("reset_sse", 64'(if0.sse), 64'(0));
    check_val("reset_mse", 64'(if0.mse), 64'(0));
    check_val("reset_max_abs_err", 64'(if0.max_abs_err), 64'(0));
    check_val("reset_overflow", 64'(if0.overflow), 64'(0));

    run_window(0, 16'sd1234, 16'sd1234, 16'sd0, 16'sd0, 1'b0, 1'b0);
    run_window(0, 16'sd3, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    run_window(0, 16'sh7fff, 16'sh8000, 16'sd0, 16'sd0, 1'b0, 1'b0);
    run_window(1, 16'sd10, 16'sd12, 16'sd100, 16'sd0, 1'b1, 1'b1);
    run_window(2, 16'sh7fff, 16'sh8000, 16'sd0, 16'sd0, 1'b0, 1'b0);
    run_window(2, 16'sd7, 16'sd7, 16'sd0, 16'sd0, 1'b0, 1'b0);

    // Abort a window after four accepted samples.
    n0 = done_cnt[0];
    step(0, 1'b1, 1'b0, 16'sd0, 16'sd0);
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 16'sd5, 16'sd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", 64'(if0.busy), 64'(0));
    check_val("abort_sse", 64'(if0.sse), 64'(0));
    check_val("abort_max_abs_err", 64'(if0.max_abs_err), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    check_val("abort_no_done", 64'(done_cnt[0]), 64'(n0));
    $display("d0 abort: busy=%0d sse=%0d", if0.busy, if0.sse);

    run_window(0, -16'sd500, 16'sd300, 16'sd0, 16'sd0, 1'b1, 1'b0);

    check_val("q_empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
